// File: rtl/hw2_operand_issue.sv
// hw2_operand_issue: operand FIFO feeding a clock-gated (a +/- b) * c datapath.
// Tuples are queued, presented one per cycle on registered outputs with an
// issue strobe (the datapath clock-gate enable), and the datapath result is
// tagged by a valid pipeline matched to the datapath latency.
module hw2_operand_issue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int LAT   = 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_in_valid,
   output logic                       o_in_ready,
   input  logic [WIDTH-1:0]           i_in_a,
   input  logic [WIDTH-1:0]           i_in_b,
   input  logic [WIDTH-1:0]           i_in_c,
   input  logic                       i_in_s,
   input  logic                       i_pause,
   output logic [WIDTH-1:0]           o_a,
   output logic [WIDTH-1:0]           o_b,
   output logic [WIDTH-1:0]           o_c,
   output logic                       o_s,
   output logic                       o_issue,
   input  logic [2*WIDTH-1:0]         i_d,
   output logic                       o_res_valid,
   output logic [2*WIDTH-1:0]         o_res_data,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 3*WIDTH + 1;

   logic [EW-1:0]    r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_c;
   logic             r_s;
   logic             r_issue;
   logic [LAT-1:0]   r_vpipe;

   logic             w_full;
   logic             w_push;
   logic             w_pop;

   // Ready depends only on registered occupancy: a pop in the same cycle
   // does not open the input, so there is no combinational ready path.
   assign w_full = (r_count == (AW+1)'(DEPTH));
   assign w_push = i_in_valid && !w_full;
   assign w_pop  = (r_count != '0) && !i_pause;

   // Storage array: written on accept, never reset (contents are data only).
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= {i_in_a, i_in_b, i_in_c, i_in_s};
      end
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Presentation registers: load on pop, otherwise hold so the gated
   // datapath inputs do not toggle while idle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_c     <= '0;
         r_s     <= 1'b1;
         r_issue <= 1'b0;
      end else begin
         r_issue <= w_pop;
         if (w_pop) begin
            {r_a, r_b, r_c, r_s} <= r_mem[r_rptr];
         end
      end
   end

   // Result-valid pipeline, LAT stages deep, fed by the issue strobe.
   generate
      if (LAT == 1) begin : g_vpipe_one
         always_ff @(posedge i_clk) begin
            if (i_rst) r_vpipe <= '0;
            else       r_vpipe <= r_issue;
         end
      end else begin : g_vpipe_many
         always_ff @(posedge i_clk) begin
            if (i_rst) r_vpipe <= '0;
            else       r_vpipe <= {r_vpipe[LAT-2:0], r_issue};
         end
      end
   endgenerate

   assign o_in_ready  = !w_full;
   assign o_a         = r_a;
   assign o_b         = r_b;
   assign o_c         = r_c;
   assign o_s         = r_s;
   assign o_issue     = r_issue;
   assign o_res_valid = r_vpipe[LAT-1];
   assign o_res_data  = i_d;
   assign o_count     = r_count;

endmodule

// File: tb/tb_hw2_operand_issue.sv
// Directed bench for hw2_operand_issue: one LAT=1 instance for directed
// scenarios and one LAT=3 instance for a randomized scoreboard run, each with
// a behavioural (a +/- b) * c datapath model of matching latency.
module tb_hw2_operand_issue;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   // LAT = 1 instance signals
   logic        v1, rdy1, s_in1, pause1, s1, iss1, rv1;
   logic [7:0]  a_in1, b_in1, c_in1, a1, b1, c1;
   logic [15:0] d1, rd1;
   logic [2:0]  cnt1;

   // LAT = 3 instance signals
   logic        v2, rdy2, s_in2, pause2, s2, iss2, rv2;
   logic [7:0]  a_in2, b_in2, c_in2, a2, b2, c2;
   logic [15:0] d2, rd2, p0, p1, p2;
   logic [2:0]  cnt2;

   hw2_operand_issue #(.WIDTH(8), .DEPTH(4), .LAT(1)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_in_valid(v1), .o_in_ready(rdy1),
      .i_in_a(a_in1), .i_in_b(b_in1), .i_in_c(c_in1), .i_in_s(s_in1),
      .i_pause(pause1), .o_a(a1), .o_b(b1), .o_c(c1), .o_s(s1),
      .o_issue(iss1), .i_d(d1), .o_res_valid(rv1), .o_res_data(rd1),
      .o_count(cnt1)
   );

   hw2_operand_issue #(.WIDTH(8), .DEPTH(4), .LAT(3)) u_dut2 (
      .i_clk(clk), .i_rst(rst), .i_in_valid(v2), .o_in_ready(rdy2),
      .i_in_a(a_in2), .i_in_b(b_in2), .i_in_c(c_in2), .i_in_s(s_in2),
      .i_pause(pause2), .o_a(a2), .o_b(b2), .o_c(c2), .o_s(s2),
      .o_issue(iss2), .i_d(d2), .o_res_valid(rv2), .o_res_data(rd2),
      .o_count(cnt2)
   );

   function automatic logic [15:0] f_dp(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic s);
      logic [15:0] t;
      t = s ? (16'(a) + 16'(b)) : (16'(a) - 16'(b));
      return 16'(t * 16'(c));
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath models: one register stage and three register stages.
   always @(posedge clk) d1 <= f_dp(a1, b1, c1, s1);
   always @(posedge clk) begin
      p0 <= f_dp(a2, b2, c2, s2);
      p1 <= p0;
      p2 <= p1;
   end
   assign d2 = p2;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_in1(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic s);
      v1 = 1'b1; a_in1 = a; b_in1 = b; c_in1 = c; s_in1 = s;
   endtask

   logic [24:0] qin[$];
   logic [15:0] qres[$];
   logic [24:0] e;
   logic        pushed, h1, h2, h3;
   int          sent, got, cyc;

   initial begin
      tests = 0; fails = 0;
      rst = 1'b1;
      v1 = 0; a_in1 = 0; b_in1 = 0; c_in1 = 0; s_in1 = 0; pause1 = 0;
      v2 = 0; a_in2 = 0; b_in2 = 0; c_in2 = 0; s_in2 = 0; pause2 = 0;
      tick(); tick();
      rst = 1'b0;
      check("rst_count", 32'(cnt1), 0);
      check("rst_ready", 32'(rdy1), 1);
      check("rst_abc", {8'h0, a1, b1, c1}, 0);
      check("rst_s", 32'(s1), 1);
      check("rst_issue", 32'(iss1), 0);
      check("rst_res_valid", 32'(rv1), 0);

      // Single op (3 + 5) * 7 = 56
      set_in1(3, 5, 7, 1); tick(); v1 = 0;
      check("t1_count_after_push", 32'(cnt1), 1);
      check("t1_no_bypass", 32'(iss1), 0);
      tick();
      check("t1_issue", 32'(iss1), 1);
      check("t1_abcs", {7'h0, a1, b1, c1, s1}, {7'h0, 8'd3, 8'd5, 8'd7, 1'b1});
      check("t1_count_after_pop", 32'(cnt1), 0);
      tick();
      check("t1_issue_drop", 32'(iss1), 0);
      check("t1_res_valid", 32'(rv1), 1);
      check("t1_res_data", 32'(rd1), 56);
      check("t1_hold_a", 32'(a1), 3);
      tick();
      check("t1_res_valid_drop", 32'(rv1), 0);

      // Back-to-back: (10-4)*6 = 36, (2-5)*3 = -9 wraps to 16'hFFF7
      set_in1(10, 4, 6, 0); tick();
      set_in1(2, 5, 3, 0); tick(); v1 = 0;
      check("t2_issue0", 32'(iss1), 1);
      check("t2_a0", 32'(a1), 10);
      tick();
      check("t2_issue1", 32'(iss1), 1);
      check("t2_a1", 32'(a1), 2);
      check("t2_rv0", 32'(rv1), 1);
      check("t2_rd0", 32'(rd1), 36);
      tick();
      check("t2_issue_drop", 32'(iss1), 0);
      check("t2_rv1", 32'(rv1), 1);
      check("t2_rd1", 32'(rd1), 32'h0000_FFF7);
      tick();
      check("t2_rv_drop", 32'(rv1), 0);

      // Full / backpressure with pause held
      pause1 = 1;
      for (int i = 0; i < 4; i++) begin
         set_in1(8'(i + 1), 1, 1, 1); tick();
      end
      check("t3_count_full", 32'(cnt1), 4);
      check("t3_ready_full", 32'(rdy1), 0);
      set_in1(5, 1, 1, 1); tick();
      check("t3_fifth_held", 32'(cnt1), 4);
      check("t3_paused_issue", 32'(iss1), 0);
      pause1 = 0; tick();
      check("t3_pop0_issue", 32'(iss1), 1);
      check("t3_pop0_a", 32'(a1), 1);
      check("t3_pop0_count", 32'(cnt1), 3);
      check("t3_ready_back", 32'(rdy1), 1);
      tick(); v1 = 0;
      check("t3_pop1_a", 32'(a1), 2);
      check("t3_fifth_accepted", 32'(cnt1), 3);
      tick();
      check("t3_pop2_a", 32'(a1), 3);
      tick();
      check("t3_pop3_a", 32'(a1), 4);
      tick();
      check("t3_pop4_a", 32'(a1), 5);
      check("t3_drained", 32'(cnt1), 0);
      tick();
      check("t3_idle_issue", 32'(iss1), 0);

      // Pause mid-stream
      pause1 = 0;
      set_in1(20, 0, 1, 1); tick();
      set_in1(21, 0, 1, 1); tick();
      check("t4_issue0", 32'(iss1), 1);
      check("t4_a0", 32'(a1), 20);
      set_in1(22, 0, 1, 1); pause1 = 1; tick(); v1 = 0;
      check("t4_pause_issue_a", 32'(iss1), 0);
      check("t4_freeze_a", 32'(a1), 20);
      check("t4_rv0", 32'(rv1), 1);
      check("t4_rd0", 32'(rd1), 20);
      tick();
      check("t4_pause_issue_b", 32'(iss1), 0);
      check("t4_freeze_b", {7'h0, a1, b1, c1, s1}, {7'h0, 8'd20, 8'd0, 8'd1, 1'b1});
      check("t4_no_extra_rv", 32'(rv1), 0);
      check("t4_count", 32'(cnt1), 2);
      pause1 = 0; tick();
      check("t4_a1", 32'(a1), 21);
      check("t4_issue1", 32'(iss1), 1);
      tick();
      check("t4_a2", 32'(a1), 22);
      check("t4_rd1", 32'(rd1), 21);
      tick();
      check("t4_issue_end", 32'(iss1), 0);
      check("t4_rd2", 32'(rd1), 22);

      // Reset mid-operation: 3 queued plus one in flight
      pause1 = 1;
      for (int i = 0; i < 4; i++) begin
         set_in1(8'(30 + i), 0, 1, 1); tick();
      end
      v1 = 0; pause1 = 0; tick();
      check("t5_inflight", 32'(iss1), 1);
      check("t5_queued", 32'(cnt1), 3);
      rst = 1; set_in1(40, 0, 1, 1); tick();
      check("t5_rst_count", 32'(cnt1), 0);
      check("t5_rst_issue", 32'(iss1), 0);
      check("t5_rst_s", 32'(s1), 1);
      check("t5_rst_a", 32'(a1), 0);
      check("t5_rst_rv", 32'(rv1), 0);
      check("t5_rst_ready", 32'(rdy1), 1);
      rst = 0; v1 = 0; tick();
      check("t5_post_rv", 32'(rv1), 0);
      check("t5_post_issue", 32'(iss1), 0);
      check("t5_post_count", 32'(cnt1), 0);

      // LAT = 3 randomized run with scoreboard
      sent = 0; got = 0; cyc = 0;
      h1 = 0; h2 = 0; h3 = 0;
      while ((got < 200) && (cyc < 5000)) begin
         if ((sent < 200) && ($urandom_range(9) < 7)) begin
            v2 = 1; a_in2 = 8'($urandom); b_in2 = 8'($urandom);
            c_in2 = 8'($urandom); s_in2 = 1'($urandom);
         end else begin
            v2 = 0;
         end
         pause2 = ($urandom_range(9) < 3);
         pushed = v2 && rdy2;
         tick(); cyc++;
         if (pushed) begin
            qin.push_back({a_in2, b_in2, c_in2, s_in2});
            sent++;
         end
         check("r_valid_latency", 32'(rv2), 32'(h3));
         if (rv2) begin
            check("r_res_pending", 32'(qres.size() > 0), 1);
            if (qres.size() > 0) check("r_res_data", 32'(rd2), 32'(qres.pop_front()));
            got++;
         end
         if (iss2) begin
            check("r_issue_pending", 32'(qin.size() > 0), 1);
            if (qin.size() > 0) begin
               e = qin.pop_front();
               check("r_issue_abcs", {7'h0, a2, b2, c2, s2}, {7'h0, e});
               qres.push_back(f_dp(e[24:17], e[16:9], e[8:1], e[0]));
            end
         end
         h3 = h2; h2 = h1; h1 = iss2;
      end
      check("r_all_results", 32'(got), 200);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
